food_spawner: RTL and testbench

- Consumes the free-running pseudo-random word from the LFSR and turns it into a legal food cell on the Snake grid.
- Candidate cells are checked against the snake-body occupancy store through a 1-cycle query port.
- After MAX_TRIES failed random draws it falls back to a deterministic row-major scan.
- Reports either a placed food cell or a grid-full condition to the game controller.

---
 rtl/food_spawner.sv | 170 +++++++++++++++++
 tb/tb_food_spawner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : food_spawner
//  Description : Turns the free-running LFSR word into a free food cell on the
//                Snake grid. Candidates are checked against the body occupancy
//                store through a one-cycle query port. After MAX_TRIES failed
//                random draws a row-major scan finds the first free cell, or
//                reports that the grid is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module food_spawner #(
  parameter int RAND_WIDTH = 32,
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 12,
  parameter int X_BITS     = 4,
  parameter int Y_BITS     = 4,
  parameter int MAX_TRIES  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RAND_WIDTH-1:0] random_in,
  input  logic                  spawn_req,
  output logic                  query_valid,
  output logic [X_BITS-1:0]     query_x,
  output logic [Y_BITS-1:0]     query_y,
  input  logic                  query_hit,
  output logic                  food_valid,
  output logic [X_BITS-1:0]     food_x,
  output logic [Y_BITS-1:0]     food_y,
  output logic                  grid_full,
  output logic                  busy
);

  // Tries counter must be able to hold MAX_TRIES itself.
  localparam int TRY_BITS = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_BITS-1:0] TRY_LIMIT = TRY_BITS'(MAX_TRIES);

  // One extra bit so a grid edge of exactly 2^X_BITS / 2^Y_BITS still fits.
  localparam logic [X_BITS:0]   X_LIMIT = (X_BITS + 1)'(GRID_W);
  localparam logic [Y_BITS:0]   Y_LIMIT = (Y_BITS + 1)'(GRID_H);
  localparam logic [X_BITS-1:0] X_LAST  = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST  = Y_BITS'(GRID_H - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_QUERY  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_SCAN_Q = 3'd4;
  localparam logic [2:0] ST_SCAN_W = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_FULL   = 3'd7;

  logic [2:0]          state;
  logic [X_BITS-1:0]   cand_x;
  logic [Y_BITS-1:0]   cand_y;
  logic [X_BITS-1:0]   scan_x;
  logic [Y_BITS-1:0]   scan_y;
  logic [TRY_BITS-1:0] tries;
  logic [TRY_BITS-1:0] tries_next;

  logic [X_BITS-1:0]   draw_x;
  logic [Y_BITS-1:0]   draw_y;
  logic                draw_in_range;
  logic                scanning;
  logic                scan_at_last;

  // Only the low X bits and the top Y bits of the LFSR word are used.
  logic                unused_rand;
  assign unused_rand = ^random_in;

  // No modulo: raw bit fields, rejected if they fall outside the grid.
  assign draw_x        = random_in[X_BITS-1:0];
  assign draw_y        = random_in[RAND_WIDTH-1 -: Y_BITS];
  assign draw_in_range = ({1'b0, draw_x} < X_LIMIT) && ({1'b0, draw_y} < Y_LIMIT);
  assign tries_next    = tries + 1'b1;
  assign scanning      = (state == ST_SCAN_Q) || (state == ST_SCAN_W);
  assign scan_at_last  = (scan_x == X_LAST) && (scan_y == Y_LAST);

  // Query address stays on the latched candidate or scan cell for the
  // strobe cycle and the following response cycle.
  assign query_valid = (state == ST_QUERY) || (state == ST_SCAN_Q);
  assign query_x     = scanning ? scan_x : cand_x;
  assign query_y     = scanning ? scan_y : cand_y;
  assign food_valid  = (state == ST_DONE);
  assign grid_full   = (state == ST_FULL);
  assign busy        = (state != ST_IDLE);

  // Main placement FSM: random draws first, row-major scan as fallback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cand_x <= '0;
      cand_y <= '0;
      scan_x <= '0;
      scan_y <= '0;
      tries  <= '0;
      food_x <= '0;
      food_y <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (spawn_req) begin
            state <= ST_SAMPLE;
            tries <= '0;
          end
        end
        ST_SAMPLE: begin
          cand_x <= draw_x;
          cand_y <= draw_y;
          tries  <= tries_next;
          if (draw_in_range) begin
            state <= ST_QUERY;
          end else if (tries_next == TRY_LIMIT) begin
            state  <= ST_SCAN_Q;
            scan_x <= '0;
            scan_y <= '0;
          end
          // otherwise stay and take the next LFSR word
        end
        ST_QUERY: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!query_hit) begin
            food_x <= cand_x;
            food_y <= cand_y;
            state  <= ST_DONE;
          end else if (tries == TRY_LIMIT) begin
            state  <= ST_SCAN_Q;
            scan_x <= '0;
            scan_y <= '0;
          end else begin
            state <= ST_SAMPLE;
          end
        end
        ST_SCAN_Q: begin
          state <= ST_SCAN_W;
        end
        ST_SCAN_W: begin
          if (!query_hit) begin
            food_x <= scan_x;
            food_y <= scan_y;
            state  <= ST_DONE;
          end else if (scan_at_last) begin
            state <= ST_FULL;
          end else begin
            if (scan_x == X_LAST) begin
              scan_x <= '0;
              scan_y <= scan_y + 1'b1;
            end else begin
              scan_x <= scan_x + 1'b1;
            end
            state <= ST_SCAN_Q;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_FULL: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_food_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_food_spawner
//  Description : Scoreboard bench for food_spawner. A request driver predicts
//                each outcome (cell, full flag, pulse cycle) from the draw
//                sequence and occupancy map; a monitor pops and compares on
//                every food_valid / grid_full pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_food_spawner;

  localparam int GW    = 16;
  localparam int GH    = 12;
  localparam int MT    = 8;
  localparam int CELLS = GW * GH;
  localparam int ND    = 32;

  logic        clk;
  logic        reset;
  logic [31:0] random_in;
  logic        spawn_req;
  logic        query_valid;
  logic [3:0]  query_x;
  logic [3:0]  query_y;
  logic        query_hit;
  logic        food_valid;
  logic [3:0]  food_x;
  logic [3:0]  food_y;
  logic        grid_full;
  logic        busy;

  food_spawner #(
    .RAND_WIDTH(32), .GRID_W(GW), .GRID_H(GH),
    .X_BITS(4), .Y_BITS(4), .MAX_TRIES(MT)
  ) dut (
    .clk(clk), .reset(reset), .random_in(random_in), .spawn_req(spawn_req),
    .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
    .query_hit(query_hit), .food_valid(food_valid), .food_x(food_x),
    .food_y(food_y), .grid_full(grid_full), .busy(busy)
  );

  typedef struct {
    bit full;
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t        exp_q[$];
  bit          occ[CELLS];
  logic [31:0] d[ND];
  int          cyc;
  int          compared;
  int          mismatched;
  int          last_x;
  int          last_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running cycle count used to check pulse timing
  always @(posedge clk) cyc <= cyc + 1;

  // occupancy store: answer one cycle after each query strobe
  always @(posedge clk) begin
    if (query_valid && int'(query_x) < GW && int'(query_y) < GH)
      query_hit <= occ[int'(query_y) * GW + int'(query_x)];
    else
      query_hit <= 1'b0;
  end

  task automatic chk(input string nm, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // monitor: legality of query addresses and scoreboard on result pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (query_valid) begin
        chk("query_in_grid", int'(int'(query_x) < GW && int'(query_y) < GH), 1);
      end
      if (food_valid || grid_full) begin
        chk("pulse_exclusive", int'(food_valid && grid_full), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("grid_full_kind", int'(grid_full), int'(e.full));
          chk("food_x", int'(food_x), e.x);
          chk("food_y", int'(food_y), e.y);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Reference: the LFSR word present at edge k after acceptance is d[k].
  // An in-range draw sampled at edge k gets its answer at edge k+2 and the
  // next draw is sampled at k+3; an out-of-range draw redraws at k+1.
  // Each scan cell costs two edges; the result pulse follows the deciding edge.
  task automatic model(output exp_t e);
    int  k, tries, sq;
    bit  found;
    found = 0;
    k     = 1;
    tries = 0;
    sq    = 0;
    e.full = 0;
    e.x = 0;
    e.y = 0;
    e.cyc = 0;
    while (!found && tries < MT) begin
      int x, y;
      x = int'(d[k][3:0]);
      y = int'(d[k][31:28]);
      tries++;
      if (x < GW && y < GH) begin
        if (!occ[y * GW + x]) begin
          found = 1; e.x = x; e.y = y; e.cyc = k + 2;
        end
        k += 3;
      end else begin
        k += 1;
      end
    end
    if (!found) begin
      sq = k - 1;
      for (int i = 0; i < CELLS && !found; i++) begin
        if (!occ[i]) begin
          found = 1; e.x = i % GW; e.y = i / GW; e.cyc = sq + 2 * i + 2;
        end
      end
      if (!found) begin
        e.full = 1; e.x = last_x; e.y = last_y; e.cyc = sq + 2 * CELLS;
      end
    end
    last_x = e.x;
    last_y = e.y;
  endtask

  task automatic run_req(input bit hold_req);
    exp_t e;
    int   n;
    model(e);
    @(negedge clk);
    spawn_req = 1'b1;
    random_in = d[0];
    @(posedge clk);
    @(negedge clk);
    e.cyc = cyc + e.cyc;
    exp_q.push_back(e);
    if (!hold_req) spawn_req = 1'b0;
    random_in = d[1];
    n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
      if (n >= 2) spawn_req = 1'b0;
      random_in = (n + 1 < ND) ? d[n + 1] : 32'h0;
    end
    spawn_req = 1'b0;
    chk("request_completes", int'(busy), 0);
  endtask

  task automatic fill_draws(input logic [31:0] v);
    for (int i = 0; i < ND; i++) d[i] = v;
  endtask

  task automatic fill_occ(input bit v);
    for (int i = 0; i < CELLS; i++) occ[i] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_food_valid"}, int'(food_valid), 0);
    chk({tag, "_grid_full"}, int'(grid_full), 0);
    chk({tag, "_query_valid"}, int'(query_valid), 0);
    chk({tag, "_food_x"}, int'(food_x), 0);
    chk({tag, "_food_y"}, int'(food_y), 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    last_x     = 0;
    last_y     = 0;
    reset      = 1'b1;
    spawn_req  = 1'b0;
    random_in  = 32'h0;
    query_hit  = 1'b0;
    fill_occ(1'b0);
    fill_draws(32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // basic placement
    fill_draws(32'h3000_0005);
    run_req(1'b0);

    // two out-of-range draws, then (7,2)
    fill_draws(32'h2000_0007);
    d[1] = 32'hF000_0005;
    d[2] = 32'hF000_0005;
    run_req(1'b0);

    // first candidate occupied, retry lands on (9,1)
    fill_draws(32'h1000_0009);
    d[1] = 32'h3000_0005;
    occ[3 * GW + 5] = 1'b1;
    run_req(1'b1);

    // all draws hit occupied cells; scan finds (2,0)
    fill_occ(1'b1);
    occ[2] = 1'b0;
    fill_draws(32'h3000_0005);
    run_req(1'b0);

    // completely full grid
    fill_occ(1'b1);
    run_req(1'b0);

    // reset while waiting for the occupancy answer
    fill_occ(1'b0);
    fill_draws(32'h3000_0005);
    @(negedge clk);
    spawn_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    spawn_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("midreset");
    last_x = 0;
    last_y = 0;

    // randomized draws and occupancy densities
    for (int r = 0; r < 24; r++) begin
      int dens;
      dens = (r % 6 == 5) ? 100 : int'($urandom_range(0, 99));
      for (int i = 0; i < CELLS; i++) occ[i] = (int'($urandom_range(0, 99)) < dens);
      for (int i = 0; i < ND; i++) begin
        logic [31:0] w;
        w = $urandom;
        w[3:0]   = 4'($urandom_range(0, 15));
        w[31:28] = 4'($urandom_range(0, 15));
        d[i] = w;
      end
      run_req(r[0]);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
